ysyx_220053_mem_arbiter: RTL

YSYX_220053_MEM_ARBITER -- requirements
Module: ysyx_220053_mem_arbiter

---
 rtl/ysyx_220053_arb_pkg.sv | 16 +
 rtl/ysyx_220053_arb_grant.sv | 41 ++++
 rtl/ysyx_220053_mem_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ysyx_220053_arb_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
// Optional round-robin grant is enabled with YSYX_220053_ARB_RR_EN.
package ysyx_220053_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_220053_arb_grant.sv
// Grant selection between fetch and load/store while the arbiter is idle.
// YSYX_220053_ARB_RR_EN selects round-robin; otherwise load/store has fixed priority.
module ysyx_220053_arb_grant
  import ysyx_220053_arb_pkg::*;
(
  input  logic       idle_i,
  input  logic       ls_valid_i,
`ifdef YSYX_220053_ARB_RR_EN
  input  logic       if_valid_i,
  input  arb_owner_e last_i,
`endif
  output logic       if_ready_o,
  output logic       ls_ready_o
);

`ifdef YSYX_220053_ARB_RR_EN
  logic if_pri;

  // On contention the requester that was not served last wins.
  assign if_pri = (last_i == OWN_LS);

  always_comb begin
    if_ready_o = 1'b0;
    ls_ready_o = 1'b0;
    if (idle_i) begin
      if_ready_o = !ls_valid_i || if_pri;
      ls_ready_o = !if_valid_i || !if_pri;
    end
  end
`else
  always_comb begin
    if_ready_o = 1'b0;
    ls_ready_o = 1'b0;
    if (idle_i) begin
      ls_ready_o = 1'b1;
      if_ready_o = !ls_valid_i;
    end
  end
`endif

endmodule

// File: rtl/ysyx_220053_mem_arbiter.sv
// Single-outstanding memory arbiter between instruction fetch and load/store.
// Define YSYX_220053_ARB_RR_EN for round-robin grant instead of load/store priority.
module ysyx_220053_mem_arbiter
  import ysyx_220053_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  // load/store requester
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  // memory side
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned MaskW = DATA_W / 8;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              wen_q,   wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MaskW-1:0]  wmask_q, wmask_d;
`ifdef YSYX_220053_ARB_RR_EN
  arb_owner_e        last_q,  last_d;
`endif

  logic idle;
  logic if_ready;
  logic ls_ready;
  logic if_fire;
  logic ls_fire;
  logic resp_fire;

  // Reset forces every handshake output low, even mid-transaction.
  assign idle = (state_q == IDLE) && !rst;

  ysyx_220053_arb_grant u_grant (
    .idle_i     (idle),
    .ls_valid_i (ls_req_valid),
`ifdef YSYX_220053_ARB_RR_EN
    .if_valid_i (if_req_valid),
    .last_i     (last_q),
`endif
    .if_ready_o (if_ready),
    .ls_ready_o (ls_ready)
  );

  assign if_req_ready = if_ready;
  assign ls_req_ready = ls_ready;
  assign if_fire      = if_req_valid && if_ready;
  assign ls_fire      = ls_req_valid && ls_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
`ifdef YSYX_220053_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (ls_fire) begin
          state_d = REQ;
          owner_d = OWN_LS;
          addr_d  = ls_addr;
          wen_d   = ls_wen;
          wdata_d = ls_wdata;
          wmask_d = ls_wmask;
`ifdef YSYX_220053_ARB_RR_EN
          last_d  = OWN_LS;
`endif
        end else if (if_fire) begin
          state_d = REQ;
          owner_d = OWN_IF;
          addr_d  = if_addr;
          wen_d   = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
`ifdef YSYX_220053_ARB_RR_EN
          last_d  = OWN_IF;
`endif
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_resp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
`ifdef YSYX_220053_ARB_RR_EN
      last_q  <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
`ifdef YSYX_220053_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign resp_fire     = (state_q == RESP) && mem_resp_valid && !rst;
  assign if_resp_valid = resp_fire && (owner_q == OWN_IF);
  assign ls_resp_valid = resp_fire && (owner_q == OWN_LS);
  assign resp_rdata    = mem_rdata;

  assign mem_req_valid = (state_q == REQ) && !rst;
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

endmodule
